// File: rtl/lin_deslin_scheduler_if.sv
// Bus between the sample front end, the shared lin/delin unit and the estimator core.
// The slave modport is the scheduler side; master is the environment side.
interface lin_deslin_scheduler_if #(
  parameter int W = 32
);
  logic         START;
  logic [W-1:0] I;
  logic [W-1:0] V;
  logic         OP_VALID;
  logic         OP_SEL;
  logic [W-1:0] OP_DATA;
  logic [W-1:0] UNIT_RESULT;
  logic [W-1:0] RESULT_I;
  logic [W-1:0] RESULT_V;
  logic         DONE;
  logic         BUSY;
  logic         ERR_OVR;

  modport slave (
    input  START, I, V, UNIT_RESULT,
    output OP_VALID, OP_SEL, OP_DATA, RESULT_I, RESULT_V, DONE, BUSY, ERR_OVR
  );

  modport master (
    output START, I, V, UNIT_RESULT,
    input  OP_VALID, OP_SEL, OP_DATA, RESULT_I, RESULT_V, DONE, BUSY, ERR_OVR
  );
endinterface

// File: rtl/lin_deslin_scheduler.sv
// Time-shares one pipelined lin/delin unit between the I and V channels:
// issue I then V back to back, collect both results LAT cycles later, pulse DONE.
module lin_deslin_scheduler #(
  parameter int W   = 32,
  parameter int LAT = 4
) (
  input  logic                    CLK,
  input  logic                    reset,
  lin_deslin_scheduler_if.slave   bus
);

  if ((LAT < 1) || (LAT > 15)) begin : g_lat_check
    $error("lin_deslin_scheduler: LAT must be within 1..15");
  end

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE_I = 3'd1;
  localparam logic [2:0] S_ISSUE_V = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_FINISH  = 3'd4;

  // Counter is cleared on the edge leaving ISSUE_I, so it reads c-2 in cycle c.
  localparam logic [4:0] CAP_I = 5'(LAT - 1);
  localparam logic [4:0] CAP_V = 5'(LAT);

  logic [2:0]   state_r,    state_n;
  logic [4:0]   cnt_r,      cnt_n;
  logic [W-1:0] v_lat_r,    v_lat_n;
  logic [W-1:0] shadow_i_r, shadow_i_n;
  logic         op_valid_r, op_valid_n;
  logic         op_sel_r,   op_sel_n;
  logic [W-1:0] op_data_r,  op_data_n;
  logic [W-1:0] result_i_r, result_i_n;
  logic [W-1:0] result_v_r, result_v_n;
  logic         done_r,     done_n;
  logic         busy_r,     busy_n;
  logic         err_ovr_r,  err_ovr_n;

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_n    = state_r;
    cnt_n      = cnt_r;
    v_lat_n    = v_lat_r;
    shadow_i_n = shadow_i_r;
    op_valid_n = 1'b0;
    op_sel_n   = 1'b0;
    op_data_n  = op_data_r;
    result_i_n = result_i_r;
    result_v_n = result_v_r;
    done_n     = 1'b0;
    busy_n     = busy_r;
    err_ovr_n  = err_ovr_r | (bus.START & busy_r);

    case (state_r)
      S_IDLE, S_FINISH: begin
        if (bus.START) begin
          state_n    = S_ISSUE_I;
          v_lat_n    = bus.V;
          op_valid_n = 1'b1;
          op_sel_n   = 1'b0;
          op_data_n  = bus.I;
          busy_n     = 1'b1;
        end else begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
        end
      end
      S_ISSUE_I: begin
        state_n    = S_ISSUE_V;
        cnt_n      = 5'd0;
        op_valid_n = 1'b1;
        op_sel_n   = 1'b1;
        op_data_n  = v_lat_r;
      end
      S_ISSUE_V: begin
        // With LAT=1 the I result already arrives during the V issue cycle.
        state_n = S_WAIT;
        cnt_n   = cnt_r + 5'd1;
        if (cnt_r == CAP_I) begin
          shadow_i_n = bus.UNIT_RESULT;
        end else begin
          shadow_i_n = shadow_i_r;
        end
      end
      S_WAIT: begin
        cnt_n = cnt_r + 5'd1;
        if (cnt_r == CAP_V) begin
          result_i_n = shadow_i_r;
          result_v_n = bus.UNIT_RESULT;
          done_n     = 1'b1;
          busy_n     = 1'b0;
          state_n    = S_FINISH;
        end else if (cnt_r == CAP_I) begin
          shadow_i_n = bus.UNIT_RESULT;
        end else begin
          shadow_i_n = shadow_i_r;
        end
      end
      default: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight transaction.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      cnt_r      <= 5'd0;
      v_lat_r    <= '0;
      shadow_i_r <= '0;
      op_valid_r <= 1'b0;
      op_sel_r   <= 1'b0;
      op_data_r  <= '0;
      result_i_r <= '0;
      result_v_r <= '0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      err_ovr_r  <= 1'b0;
    end else begin
      state_r    <= state_n;
      cnt_r      <= cnt_n;
      v_lat_r    <= v_lat_n;
      shadow_i_r <= shadow_i_n;
      op_valid_r <= op_valid_n;
      op_sel_r   <= op_sel_n;
      op_data_r  <= op_data_n;
      result_i_r <= result_i_n;
      result_v_r <= result_v_n;
      done_r     <= done_n;
      busy_r     <= busy_n;
      err_ovr_r  <= err_ovr_n;
    end
  end

  assign bus.OP_VALID = op_valid_r;
  assign bus.OP_SEL   = op_sel_r;
  assign bus.OP_DATA  = op_data_r;
  assign bus.RESULT_I = result_i_r;
  assign bus.RESULT_V = result_v_r;
  assign bus.DONE     = done_r;
  assign bus.BUSY     = busy_r;
  assign bus.ERR_OVR  = err_ovr_r;

endmodule

// File: tb/tb_lin_deslin_scheduler.sv
// Bench for lin_deslin_scheduler: LAT=4 and LAT=1 instances, each with a pipelined
// unit model (I: +1, V: <<1), a vector table and a DONE scoreboard.
module tb_lin_deslin_scheduler;

  localparam int L4 = 4;
  localparam int L1 = 1;

  logic CLK;
  logic reset;

  lin_deslin_scheduler_if #(.W(32)) bus4 ();
  lin_deslin_scheduler_if #(.W(32)) bus1 ();

  lin_deslin_scheduler #(.W(32), .LAT(L4)) dut4 (.CLK(CLK), .reset(reset), .bus(bus4));
  lin_deslin_scheduler #(.W(32), .LAT(L1)) dut1 (.CLK(CLK), .reset(reset), .bus(bus1));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Unit models: results emerge LAT cycles after the issue cycle; junk otherwise.
  logic [31:0] pipe4 [0:L4-1];
  logic [31:0] pipe1 [0:L1-1];

  always @(posedge CLK) begin
    pipe4[0] <= bus4.OP_VALID ? (bus4.OP_SEL ? (bus4.OP_DATA << 1) : (bus4.OP_DATA + 32'd1)) : $urandom;
    for (int k = 1; k < L4; k++) pipe4[k] <= pipe4[k-1];
    pipe1[0] <= bus1.OP_VALID ? (bus1.OP_SEL ? (bus1.OP_DATA << 1) : (bus1.OP_DATA + 32'd1)) : $urandom;
  end

  assign bus4.UNIT_RESULT = pipe4[L4-1];
  assign bus1.UNIT_RESULT = pipe1[L1-1];

  logic [100:0] outs4, outs1;
  assign outs4 = {bus4.OP_VALID, bus4.OP_SEL, bus4.OP_DATA, bus4.RESULT_I, bus4.RESULT_V,
                  bus4.DONE, bus4.BUSY, bus4.ERR_OVR};
  assign outs1 = {bus1.OP_VALID, bus1.OP_SEL, bus1.OP_DATA, bus1.RESULT_I, bus1.RESULT_V,
                  bus1.DONE, bus1.BUSY, bus1.ERR_OVR};

  typedef struct {
    logic [31:0] i;
    logic [31:0] v;
    logic [31:0] exp_i;
    logic [31:0] exp_v;
  } vec_t;

  vec_t        tbl [5];
  logic [63:0] q4 [$];
  logic [63:0] q1 [$];
  int          total;
  int          passed;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advance one cycle, sample #1 after the edge and score any DONE.
  task automatic tick();
    logic [63:0] e;
    @(posedge CLK);
    #1;
    if (bus4.DONE) begin
      if (q4.size() == 0) chk("done4_unexpected", 128'(bus4.DONE), 128'd0);
      else begin
        e = q4.pop_front();
        chk("done4_result_i", 128'(bus4.RESULT_I), 128'(e[63:32]));
        chk("done4_result_v", 128'(bus4.RESULT_V), 128'(e[31:0]));
      end
    end
    if (bus1.DONE) begin
      if (q1.size() == 0) chk("done1_unexpected", 128'(bus1.DONE), 128'd0);
      else begin
        e = q1.pop_front();
        chk("done1_result_i", 128'(bus1.RESULT_I), 128'(e[63:32]));
        chk("done1_result_v", 128'(bus1.RESULT_V), 128'(e[31:0]));
      end
    end
  endtask

  initial begin
    logic [31:0] prev_i, prev_v;
    total  = 0;
    passed = 0;
    tbl[0] = '{32'h0000_0010, 32'h0000_0020, 32'h0000_0011, 32'h0000_0040};
    tbl[1] = '{32'h0000_0001, 32'h0000_0003, 32'h0000_0002, 32'h0000_0006};
    tbl[2] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
    tbl[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFE};
    tbl[4] = '{32'h1234_5678, 32'h0F0F_0F0F, 32'h1234_5679, 32'h1E1E_1E1E};

    reset      = 1'b0;
    bus4.START = 1'b0; bus4.I = 32'd0; bus4.V = 32'd0;
    bus1.START = 1'b0; bus1.I = 32'd0; bus1.V = 32'd0;

    // Reset held with random stimulus: everything stays zero.
    for (int c = 0; c < 3; c++) begin
      bus4.START = 1'($urandom); bus4.I = $urandom; bus4.V = $urandom;
      bus1.START = 1'($urandom); bus1.I = $urandom; bus1.V = $urandom;
      tick();
      chk("reset_outs4", 128'(outs4), 128'd0);
      chk("reset_outs1", 128'(outs1), 128'd0);
    end
    bus4.START = 1'b0; bus1.START = 1'b0;
    reset = 1'b1;
    tick();
    chk("idle_outs4", 128'(outs4), 128'd0);

    // Back-to-back transactions from the table; START lands in each DONE cycle.
    prev_i = 32'd0;
    prev_v = 32'd0;
    for (int n = 0; n < 5; n++) begin
      bus4.START = 1'b1; bus4.I = tbl[n].i; bus4.V = tbl[n].v;
      q4.push_back({tbl[n].exp_i, tbl[n].exp_v});
      tick();
      bus4.START = 1'b0; bus4.I = $urandom; bus4.V = $urandom;
      chk("issue_i_valid", 128'(bus4.OP_VALID), 128'd1);
      chk("issue_i_sel",   128'(bus4.OP_SEL),   128'd0);
      chk("issue_i_data",  128'(bus4.OP_DATA),  128'(tbl[n].i));
      chk("issue_i_busy",  128'(bus4.BUSY),     128'd1);
      tick();
      chk("issue_v_valid", 128'(bus4.OP_VALID), 128'd1);
      chk("issue_v_sel",   128'(bus4.OP_SEL),   128'd1);
      chk("issue_v_data",  128'(bus4.OP_DATA),  128'(tbl[n].v));
      chk("issue_v_busy",  128'(bus4.BUSY),     128'd1);
      for (int c = 3; c <= L4 + 2; c++) begin
        tick();
        chk("wait_valid",  128'(bus4.OP_VALID), 128'd0);
        chk("wait_sel",    128'(bus4.OP_SEL),   128'd0);
        chk("wait_busy",   128'(bus4.BUSY),     128'd1);
        chk("wait_done",   128'(bus4.DONE),     128'd0);
        chk("hold_res_i",  128'(bus4.RESULT_I), 128'(prev_i));
        chk("hold_res_v",  128'(bus4.RESULT_V), 128'(prev_v));
      end
      tick();
      chk("done_strobe", 128'(bus4.DONE), 128'd1);
      chk("done_busy",   128'(bus4.BUSY), 128'd0);
      chk("no_err",      128'(bus4.ERR_OVR), 128'd0);
      prev_i = tbl[n].exp_i;
      prev_v = tbl[n].exp_v;
    end

    // Overrun: START pulsed in cycle 3 is ignored but flagged.
    bus4.START = 1'b1; bus4.I = 32'h5; bus4.V = 32'h7;
    q4.push_back({32'h6, 32'hE});
    tick();
    bus4.START = 1'b0;
    tick();
    tick();
    chk("ovr_err_before", 128'(bus4.ERR_OVR), 128'd0);
    bus4.START = 1'b1; bus4.I = $urandom; bus4.V = $urandom;
    for (int c = 4; c <= 6; c++) begin
      tick();
      bus4.START = 1'b0;
      chk("ovr_err_set",  128'(bus4.ERR_OVR),  128'd1);
      chk("ovr_no_issue", 128'(bus4.OP_VALID), 128'd0);
    end
    tick();
    chk("ovr_done", 128'(bus4.DONE), 128'd1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("ovr_err_sticky", 128'(bus4.ERR_OVR),  128'd1);
      chk("ovr_no_extra",   128'(bus4.OP_VALID), 128'd0);
      chk("ovr_no_done",    128'(bus4.DONE),     128'd0);
    end

    // Abort: reset in cycle 4 discards the transaction.
    bus4.START = 1'b1; bus4.I = 32'h30; bus4.V = 32'h40;
    tick();
    bus4.START = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b0;
    q4.delete();
    #1;
    chk("abort_outs_c4", 128'(outs4), 128'd0);
    tick();
    chk("abort_outs_c5", 128'(outs4), 128'd0);
    reset = 1'b1;
    for (int c = 6; c <= 7; c++) begin
      tick();
      chk("abort_outs_after", 128'(outs4), 128'd0);
    end
    tick();
    bus4.START = 1'b1; bus4.I = 32'h100; bus4.V = 32'h200;
    q4.push_back({32'h101, 32'h400});
    tick();
    bus4.START = 1'b0;
    for (int c = 2; c <= L4 + 2; c++) begin
      tick();
      chk("post_abort_no_done", 128'(bus4.DONE), 128'd0);
    end
    tick();
    chk("post_abort_done", 128'(bus4.DONE), 128'd1);

    // LAT=1 instance: DONE in cycle 4, BUSY in cycles 1..3.
    bus1.START = 1'b1; bus1.I = 32'h40; bus1.V = 32'h41;
    q1.push_back({32'h41, 32'h82});
    tick();
    bus1.START = 1'b0; bus1.I = $urandom; bus1.V = $urandom;
    chk("l1_c1_busy",  128'(bus1.BUSY),     128'd1);
    chk("l1_c1_valid", 128'(bus1.OP_VALID), 128'd1);
    chk("l1_c1_data",  128'(bus1.OP_DATA),  128'h40);
    tick();
    chk("l1_c2_busy",  128'(bus1.BUSY),     128'd1);
    chk("l1_c2_sel",   128'(bus1.OP_SEL),   128'd1);
    chk("l1_c2_data",  128'(bus1.OP_DATA),  128'h41);
    tick();
    chk("l1_c3_busy",  128'(bus1.BUSY),     128'd1);
    chk("l1_c3_done",  128'(bus1.DONE),     128'd0);
    tick();
    chk("l1_c4_done",  128'(bus1.DONE),     128'd1);
    chk("l1_c4_busy",  128'(bus1.BUSY),     128'd0);
    tick();
    chk("l1_c5_busy",  128'(bus1.BUSY),     128'd0);
    chk("l1_c5_done",  128'(bus1.DONE),     128'd0);

    chk("q4_drained", 128'(q4.size()), 128'd0);
    chk("q1_drained", 128'(q1.size()), 128'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
